// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial sequence detector.
package seq_det_pkg;

  localparam int         DEF_PATTERN_W = 4;
  localparam logic [3:0] DEF_PATTERN   = 4'b1011;
  localparam int         DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins but still counts a coincident increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         async_reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = inc ? W'(1) : '0;
    else if (inc && !sat_q) cnt_d = cnt_q + W'(1);
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/serial_seq_detector.sv
// Serial pattern detector with fill-tracking FSM and saturating match counter.
// Define SEQ_DET_OVERLAP_EN to allow overlapping matches (stay ARMED after a hit).
module serial_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int                   CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 async_reset_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear_cnt,
  output logic                 detect,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 cnt_sat,
  output logic [PATTERN_W-1:0] hist
);

  localparam int FW = $clog2(PATTERN_W + 1);

  det_state_e           state_q, state_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [PATTERN_W-1:0] hist_q, hist_shift;
  logic                 detect_q;
  logic                 complete, match;

  assign hist_shift = {hist_q[PATTERN_W-2:0], bit_in};
  // A window is only comparable once PATTERN_W bits exist, including the bit arriving now.
  assign complete   = bit_valid &&
                      ((state_q == ARMED) ||
                       (state_q == FILLING && fill_q == FW'(PATTERN_W - 1)));
  assign match      = complete && (hist_shift == PATTERN);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (bit_valid) begin
      unique case (state_q)
        EMPTY: begin
          state_d = FILLING;
          fill_d  = FW'(1);
        end
        FILLING: begin
          fill_d = fill_q + FW'(1);
          if (fill_q == FW'(PATTERN_W - 1)) state_d = ARMED;
        end
        ARMED: ;
        default: begin
          state_d = EMPTY;
          fill_d  = '0;
        end
      endcase
`ifndef SEQ_DET_OVERLAP_EN
      if (match) begin
        state_d = EMPTY;
        fill_d  = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q  <= EMPTY;
      fill_q   <= '0;
      hist_q   <= '0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      detect_q <= match;
      if (bit_valid) hist_q <= hist_shift;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .inc           (match),
    .clr           (clear_cnt),
    .cnt           (match_cnt),
    .sat           (cnt_sat)
  );

  assign detect = detect_q;
  assign hist   = hist_q;

endmodule

// File: tb/tb_serial_seq_detector.sv
// Self-checking bench: vector table, directed corner sequences and a randomized model comparison.
module tb_serial_seq_detector;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       async_reset_n = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0, clear_cnt = 1'b0;
  logic       detect, cnt_sat, detect2, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [3:0] hist, hist2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_seq_detector dut (
    .clk(clk), .async_reset_n(async_reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_cnt(clear_cnt), .detect(detect), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .hist(hist)
  );

  serial_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .async_reset_n(async_reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_cnt(clear_cnt), .detect(detect2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2), .hist(hist2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    bit_valid = v; bit_in = b; clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bit_valid = 1'b0; clear_cnt = 1'b0;
    async_reset_n = 1'b0;
    @(posedge clk);
    #1 async_reset_n = 1'b1;
  endtask

  typedef struct {
    logic       rst, v, b, c;
    logic       det;
    int         cnt;
    logic [3:0] hist;
  } vec_t;

  // Reference model: counts valid bits since last reset/non-overlapped hit, compares last 4 bits.
  int         m_n, m_cnt;
  logic [3:0] m_hist;
  logic       m_det;

  task automatic model_reset();
    m_n = 0; m_cnt = 0; m_hist = 4'd0; m_det = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic c);
    logic hit;
    hit = 1'b0;
    if (v) begin
      m_hist = {m_hist[2:0], b};
      m_n = (m_n < 4) ? m_n + 1 : 4;
      hit = (m_n == 4) && (m_hist == DEF_PATTERN);
`ifndef SEQ_DET_OVERLAP_EN
      if (hit) m_n = 0;
`endif
    end
    m_det = hit;
    if (c)                      m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  vec_t vecs[$];
  int   ndet;
  logic [6:0] ovl;

  initial begin
    // basic 1011 match, clear alone, gapped stream, bit_in ignored while invalid
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0001});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0010});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0101});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b1011});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4'b1011});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 4'b1011});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0001});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0010});
    for (int g = 0; g < 5; g++)
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'b0010});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0101});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b1011});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4'b1011});

    @(posedge clk);
    #1;
    chk("rst_det", detect, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_sat", cnt_sat, 0);
    chk("rst_hist", hist, 0);
    chk("rst_state", int'(dut.state_q), int'(EMPTY));
    async_reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else             step(vecs[i].v, vecs[i].b, vecs[i].c);
      chk($sformatf("vec%0d_det", i), detect, vecs[i].det);
      chk($sformatf("vec%0d_cnt", i), match_cnt, vecs[i].cnt);
      chk($sformatf("vec%0d_hist", i), hist, vecs[i].hist);
    end

    // overlapping stream 1011011
    do_reset();
    ovl = 7'b1011011;
    ndet = 0;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, ovl[i], 1'b0);
      ndet += int'(detect);
    end
`ifdef SEQ_DET_OVERLAP_EN
    chk("overlap_detects", ndet, 2);
`else
    chk("overlap_detects", ndet, 1);
`endif

    // saturation with a 2-bit counter, then clear coincident with a match
    do_reset();
    for (int m = 1; m <= 5; m++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, m == 5);
      chk($sformatf("sat_m%0d_det", m), detect2, 1);
      if (m == 2) chk("sat_m2_cnt", match_cnt2, 2);
      if (m == 2) chk("sat_m2_sat", cnt_sat2, 0);
      if (m >= 3 && m <= 4) chk($sformatf("sat_m%0d_cnt", m), match_cnt2, 3);
      if (m >= 3 && m <= 4) chk($sformatf("sat_m%0d_sat", m), cnt_sat2, 1);
    end
    chk("clr_hit_cnt", match_cnt2, 1);
    chk("clr_hit_sat", cnt_sat2, 0);

    // reset pulse between edges discards a partial pattern
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    bit_valid = 1'b0;
    async_reset_n = 1'b0;
    #1;
    chk("midrst_async_hist", hist, 0);
    chk("midrst_async_state", int'(dut.state_q), int'(EMPTY));
    #1 async_reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("midrst_det", detect, 0);
    chk("midrst_hist", hist, 1);
    chk("midrst_state", int'(dut.state_q), int'(FILLING));
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("midrst_early_det", detect, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("midrst_final_det", detect, 1);

    // randomized comparison against the model
    do_reset();
    model_reset();
    for (int t = 0; t < 800; t++) begin
      logic v, b, c;
      v = ($urandom_range(0, 3) != 0);
      b = $urandom_range(0, 1);
      c = ($urandom_range(0, 29) == 0);
      step(v, b, c);
      model_step(v, b, c);
      chk("rnd_det", detect, m_det);
      chk("rnd_cnt", match_cnt, m_cnt);
      chk("rnd_sat", cnt_sat, m_cnt == 255);
      chk("rnd_hist", hist, m_hist);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
